// File: rtl/mdu_multicycle.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at accept, held in a pending register, and committed after the programmed latency.
`timescale 1ns/1ps
module mdu_multicycle #(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             flush,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MADD  = 3'b110;
   localparam logic [2:0] OP_MSUB  = 3'b111;

   localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW    = $clog2(MAX_L + 1);
   localparam logic [CW-1:0] MUL_L   = CW'(MUL_CYCLES);
   localparam logic [CW-1:0] DIV_L   = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [CW-1:0]           count;
   logic [2*WIDTH-1:0]      pending;
   logic [2*WIDTH-1:0]      pending_next;
   logic signed [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0]      prod_u;
   logic [WIDTH-1:0]        div_b_s;
   logic [WIDTH-1:0]        div_b_u;
   logic signed [WIDTH-1:0] q_s;
   logic signed [WIDTH-1:0] r_s;
   logic [WIDTH-1:0]        q_u;
   logic [WIDTH-1:0]        r_u;
   logic                    div_zero;
   logic                    div_ovf;
   logic                    is_div;

   assign busy = (count != '0);

   assign prod_s = $signed({{WIDTH{A[WIDTH-1]}}, A}) * $signed({{WIDTH{B[WIDTH-1]}}, B});
   assign prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

   // Dividing most-negative by one yields exactly the required overflow result
   // (quotient = most-negative, remainder = 0), so the overflow case reuses the divider.
   assign div_zero = (B == '0);
   assign div_ovf  = (A == MOST_NEG) && (B == ALL_ONES);
   assign div_b_s  = (div_zero || div_ovf) ? ONE : B;
   assign div_b_u  = div_zero ? ONE : B;
   assign q_s      = $signed(A) / $signed(div_b_s);
   assign r_s      = $signed(A) % $signed(div_b_s);
   assign q_u      = A / div_b_u;
   assign r_u      = A % div_b_u;

   assign is_div = (op == OP_DIV) || (op == OP_DIVU);

   always_comb begin
      pending_next = {hi, lo};
      case (op)
         OP_MULT:  pending_next = prod_s;
         OP_MULTU: pending_next = prod_u;
         OP_DIV:   pending_next = div_zero ? {A, ALL_ONES} : {r_s, q_s};
         OP_DIVU:  pending_next = div_zero ? {A, ALL_ONES} : {r_u, q_u};
         OP_MADD:  pending_next = {hi, lo} + prod_s;
         OP_MSUB:  pending_next = {hi, lo} - prod_s;
         default:  pending_next = {hi, lo};
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hi      <= '0;
         lo      <= '0;
         count   <= '0;
         pending <= '0;
      end else if (flush) begin
         // Cancels any in-flight op (commit included) and blocks this cycle's start.
         count <= '0;
      end else if (busy) begin
         count <= count - CNT_ONE;
         if (count == CNT_ONE) begin
            {hi, lo} <= pending;
         end
      end else if (start) begin
         case (op)
            OP_MTHI: hi <= A;
            OP_MTLO: lo <= A;
            default: begin
               pending <= pending_next;
               count   <= is_div ? DIV_L : MUL_L;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_multicycle.sv
// Self-checking bench for mdu_multicycle: directed scenarios plus randomized ops
// checked against an arithmetic reference model of HI/LO.
`timescale 1ns/1ps
module tb_mdu_multicycle;

   localparam int W     = 32;
   localparam int MUL_L = 5;
   localparam int DIV_L = 10;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [2:0]    op;
   logic [W-1:0]  a_in;
   logic [W-1:0]  b_in;
   logic          flush;
   logic          busy;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int n_checks = 0;
   int n_errors = 0;

   logic [W-1:0]   exp_hi;
   logic [W-1:0]   exp_lo;
   logic [2*W-1:0] exp_q[$];

   mdu_multicycle #(.WIDTH(W), .MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(a_in), .B(b_in),
      .flush(flush), .busy(busy), .hi(hi), .lo(lo)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the {hi,lo} an op leaves behind, from plain 64-bit arithmetic.
   function automatic logic [2*W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [2*W-1:0] hl);
      longint sa, sb, q, r;
      logic [63:0] ua, ub, uq, ur, t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      t  = hl;
      case (o)
         3'd0: t = 64'(sa * sb);
         3'd1: t = ua * ub;
         3'd2: if (b == 0) t = {a, 32'hFFFF_FFFF};
               else begin q = sa / sb; r = sa % sb; uq = 64'(q); ur = 64'(r); t = {ur[31:0], uq[31:0]}; end
         3'd3: if (b == 0) t = {a, 32'hFFFF_FFFF};
               else begin uq = ua / ub; ur = ua % ub; t = {ur[31:0], uq[31:0]}; end
         3'd4: t = {a, hl[31:0]};
         3'd5: t = {hl[63:32], a};
         3'd6: t = hl + 64'(sa * sb);
         3'd7: t = hl - 64'(sa * sb);
         default: t = hl;
      endcase
      return t;
   endfunction

   function automatic int ref_latency(input logic [2:0] o);
      if (o == 3'd4 || o == 3'd5) return 0;
      if (o == 3'd2 || o == 3'd3) return DIV_L;
      return MUL_L;
   endfunction

   // driver: issue one op at a negedge, return the number of busy cycles seen after it
   task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int nbusy);
      @(negedge clk);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(negedge clk);
      start = 1'b0;
      nbusy = 0;
      while (busy && nbusy < 200) begin
         nbusy++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      exp_hi = '0; exp_lo = '0;
      n_checks++;
      if ({busy, hi, lo} !== {1'b0, 64'h0}) begin
         n_errors++;
         $display("FAIL reset: busy=%b hi=%h lo=%h, want busy=0 hi=0 lo=0", busy, hi, lo);
      end
   endtask

   task automatic test_mult();
      int nb;
      do_op(3'd0, 32'hFFFF_FFFE, 32'd3, nb);
      n_checks++;
      if (nb !== MUL_L || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
         n_errors++;
         $display("FAIL mult: busy=%0d hi=%h lo=%h, want %0d ffffffff fffffffa", nb, hi, lo, MUL_L);
      end
      do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, nb);
      n_checks++;
      if (nb !== MUL_L || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         n_errors++;
         $display("FAIL multu: busy=%0d hi=%h lo=%h, want %0d fffffffe 00000001", nb, hi, lo, MUL_L);
      end
      exp_hi = hi === 32'hFFFF_FFFE ? 32'hFFFF_FFFE : 32'hFFFF_FFFE; exp_lo = 32'h1;
   endtask

   task automatic test_div();
      int nb;
      do_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb);
      n_checks++;
      if (nb !== DIV_L || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         n_errors++;
         $display("FAIL div: busy=%0d hi=%h lo=%h, want %0d ffffffff fffffffd", nb, hi, lo, DIV_L);
      end
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb);
      n_checks++;
      if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
         n_errors++;
         $display("FAIL div_ovf: hi=%h lo=%h, want 00000000 80000000", hi, lo);
      end
      do_op(3'd3, 32'h1234, 32'h0, nb);
      n_checks++;
      if (nb !== DIV_L || lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin
         n_errors++;
         $display("FAIL divu_zero: busy=%0d hi=%h lo=%h, want %0d 00001234 ffffffff", nb, hi, lo, DIV_L);
      end
      do_op(3'd4, 32'd5, 32'd0, nb);
      n_checks++;
      if (nb !== 0 || hi !== 32'd5 || lo !== 32'hFFFF_FFFF) begin
         n_errors++;
         $display("FAIL mthi: busy=%0d hi=%h lo=%h, want 0 00000005 ffffffff", nb, hi, lo);
      end
      exp_hi = 32'd5; exp_lo = 32'hFFFF_FFFF;
   endtask

   task automatic test_madd_msub();
      int nb;
      do_op(3'd5, 32'd10, 32'd0, nb);
      do_op(3'd4, 32'd0, 32'd0, nb);
      do_op(3'd6, 32'd3, 32'd4, nb);
      n_checks++;
      if (nb !== MUL_L || hi !== 32'd0 || lo !== 32'd22) begin
         n_errors++;
         $display("FAIL madd: busy=%0d hi=%h lo=%h, want %0d 00000000 00000016", nb, hi, lo, MUL_L);
      end
      do_op(3'd7, 32'd1, 32'd30, nb);
      n_checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF8) begin
         n_errors++;
         $display("FAIL msub: hi=%h lo=%h, want ffffffff fffffff8", hi, lo);
      end
      exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFFFF_FFF8;
   endtask

   task automatic test_flush();
      // DIV accepted in cycle t, flushed in cycle t+3
      @(negedge clk);
      start = 1'b1; op = 3'd2; a_in = 32'd100; b_in = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_pre: busy=%b, want 1", busy);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
         n_errors++;
         $display("FAIL flush_mid: busy=%b hi=%h lo=%h, want 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
      end
      // MULT flushed exactly in its commit cycle t+L
      @(negedge clk);
      start = 1'b1; op = 3'd1; a_in = 32'd9; b_in = 32'd9;
      @(negedge clk);
      start = 1'b0;
      repeat (MUL_L - 1) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
         n_errors++;
         $display("FAIL flush_commit: busy=%b hi=%h lo=%h, want 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_start_ignored();
      int nb;
      logic [2*W-1:0] e;
      e = ref_op(3'd0, 32'd6, 32'd7, {exp_hi, exp_lo});
      @(negedge clk);
      start = 1'b1; op = 3'd0; a_in = 32'd6; b_in = 32'd7;
      @(negedge clk);
      op = 3'd4; a_in = 32'hDEAD;  // MTHI while busy must be dropped
      @(negedge clk);
      start = 1'b0;
      nb = 1;
      while (busy && nb < 200) begin
         nb++;
         @(negedge clk);
      end
      n_checks++;
      if (nb !== MUL_L || {hi, lo} !== e) begin
         n_errors++;
         $display("FAIL start_busy: busy=%0d hilo=%h, want %0d %h", nb, {hi, lo}, MUL_L, e);
      end
      exp_hi = e[63:32]; exp_lo = e[31:0];
      // start together with flush: neither MTHI nor MULT is accepted
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = 3'd4; a_in = 32'h77;
      @(negedge clk);
      op = 3'd0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
         n_errors++;
         $display("FAIL start_flush: busy=%b hi=%h lo=%h, want 0 %h %h", busy, hi, lo, exp_hi, exp_lo);
      end
   endtask

   task automatic test_reset_midop();
      int nb;
      do_op(3'd4, 32'hA5A5_0001, 32'd0, nb);
      @(negedge clk);
      start = 1'b1; op = 3'd2; a_in = 32'd50; b_in = 32'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (DIV_L) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_midop: busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
      end
      exp_hi = '0; exp_lo = '0;
   endtask

   task automatic test_random();
      int nb;
      logic [2:0]     o;
      logic [W-1:0]   a, b;
      logic [2*W-1:0] e;
      for (int i = 0; i < 60; i++) begin
         o = 3'($urandom_range(0, 7));
         a = $urandom();
         b = $urandom();
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = 32'($urandom_range(1, 9));
            default: ;
         endcase
         exp_q.push_back(ref_op(o, a, b, {exp_hi, exp_lo}));
         do_op(o, a, b, nb);
         e = exp_q.pop_front();
         n_checks++;
         if (nb !== ref_latency(o) || {hi, lo} !== e) begin
            n_errors++;
            $display("FAIL random[%0d] op=%0d a=%h b=%h: busy=%0d hilo=%h, want %0d %h",
                     i, o, a, b, nb, {hi, lo}, ref_latency(o), e);
         end
         exp_hi = e[63:32]; exp_lo = e[31:0];
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_madd_msub();
      test_flush();
      test_start_ignored();
      test_reset_midop();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
